// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor : resets the system PLL, qualifies its lock and releases
// sys_rst / ready.  Optional lock-loss counter: PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
// Revision: 1.0
// ============================================================================
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES    = 3,
   localparam int RETRY_W       = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [7:0]         lock_loss_cnt
);

   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABILIZE = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [1:0]         sync_q, sync_d;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_q, sys_rst_d;
   logic               ready_q, ready_d;
   logic               fail_q, fail_d;
   logic               locked_s;

   assign locked_s = sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], pll_locked};
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;

      unique case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         S_WAIT_LOCK: begin
            // A lock arriving on the timeout edge takes priority over the retry.
            if (locked_s) begin
               state_d = S_STABILIZE;
            end else if (cnt_q == TO_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = S_FAIL;
               end else begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_RESET_PLL;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STABILIZE: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STB_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!locked_s) state_d = S_RESET_PLL;
         end
         S_FAIL: begin
            state_d = S_FAIL;
         end
         default: begin
            state_d = S_RESET_PLL;
         end
      endcase

      if (state_d != state_q) cnt_d = '0;

      // Outputs follow the next state so they change on the transition edge.
      pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_d = (state_d != S_RUN);
      ready_d   = (state_d == S_RUN);
      fail_d    = (state_d == S_FAIL);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= '0;
         retry_q   <= '0;
         sync_q    <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         sync_q    <= sync_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
   logic [7:0] loss_q, loss_d;

   always_comb begin
      loss_d = loss_q;
      if ((state_q == S_RUN) && (state_d == S_RESET_PLL) && (loss_q != 8'hFF))
         loss_d = loss_q + 8'd1;
   end

   always_ff @(posedge refclk) begin
      if (rst) loss_q <= 8'd0;
      else     loss_q <= loss_d;
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = 8'd0;
`endif

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_supervisor : directed vector table, corner sequences and a random
// lock waveform checked against a timestamp-based reference model.
// Revision: 1.0
// ============================================================================
module tb_pll_lock_supervisor;

   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 20;
   localparam int STABLE_CYCLES  = 8;
   localparam int MAX_RETRIES    = 2;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif
   localparam int L1 = LOSS_EN ? 1 : 0;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_rst, ready, fail;
   logic [1:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   always #10 refclk = ~refclk;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES(PLL_RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .fail         (fail),
      .retry_cnt    (retry_cnt),
      .lock_loss_cnt(lock_loss_cnt)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: phase plus the cycle it was entered; dwell times come
   // from elapsed cycles rather than a counter.
   localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAIL = 4;
   int m_cyc = 0, m_enter = 0, m_phase = PH_RST, m_retries = 0, m_losses = 0;
   bit m_s1 = 1'b0, m_s2 = 1'b0;

   function automatic void enter(input int p);
      m_phase = p;
      m_enter = m_cyc;
   endfunction

   function automatic void model_step(input bit r, input bit lk);
      bit ls;
      int age;
      m_cyc++;
      if (r) begin
         enter(PH_RST);
         m_retries = 0;
         m_losses  = 0;
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         return;
      end
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      age  = m_cyc - m_enter;
      case (m_phase)
         PH_RST:  if (age >= PLL_RST_CYCLES) enter(PH_WAIT);
         PH_WAIT: begin
            if (ls) enter(PH_STAB);
            else if (age >= LOCK_TIMEOUT) begin
               if (m_retries >= MAX_RETRIES) enter(PH_FAIL);
               else begin
                  m_retries++;
                  enter(PH_RST);
               end
            end
         end
         PH_STAB: begin
            if (!ls) enter(PH_WAIT);
            else if (age >= STABLE_CYCLES) begin
               enter(PH_RUN);
               m_retries = 0;
            end
         end
         PH_RUN: begin
            if (!ls) begin
               enter(PH_RST);
               if (LOSS_EN && m_losses < 255) m_losses++;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic check_model();
      logic [19:0] act, exp;
      act = {pll_rst, sys_rst, ready, fail, 6'(retry_cnt), lock_loss_cnt};
      exp = {(m_phase == PH_RST || m_phase == PH_FAIL), (m_phase != PH_RUN),
             (m_phase == PH_RUN), (m_phase == PH_FAIL), 6'(m_retries), 8'(m_losses)};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL model cyc=%0d actual pr/sr/rdy/fl/rc/llc=%b%b%b%b/%0d/%0d required=%b%b%b%b/%0d/%0d",
                  m_cyc, act[19], act[18], act[17], act[16], act[13:8], act[7:0],
                  exp[19], exp[18], exp[17], exp[16], exp[13:8], exp[7:0]);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      model_step(rst, pll_locked);
      #1;
      check_model();
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   typedef struct {
      int n;
      bit r, lk;
      bit pr, sr, rd, fl;
      int rc, llc;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input int n, input bit r, input bit lk, input bit pr, input bit sr,
                               input bit rd, input bit fl, input int rc, input int llc);
      vec_t v;
      v = '{n, r, lk, pr, sr, rd, fl, rc, llc};
      tbl.push_back(v);
   endfunction

   initial begin
      int k, edges;
      bit saw_pr, saw_rc, timed_out;

      //   n    rst lk   pr sr rd fl  rc llc
      add(3,   1, 0,    1, 1, 0, 0,  0, 0);   // reset state
      add(3,   0, 0,    1, 1, 0, 0,  0, 0);   // pll_rst held
      add(1,   0, 0,    0, 1, 0, 0,  0, 0);   // falls after 4 cycles
      add(2,   0, 0,    0, 1, 0, 0,  0, 0);
      add(10,  0, 1,    0, 1, 0, 0,  0, 0);   // lock qualifying
      add(1,   0, 1,    0, 0, 1, 0,  0, 0);   // ready on 11th edge
      add(2,   0, 0,    0, 0, 1, 0,  0, 0);   // lock dropped, still RUN
      add(1,   0, 0,    1, 1, 0, 0,  0, L1);  // restart 2 edges later
      add(3,   0, 0,    1, 1, 0, 0,  0, L1);
      add(1,   0, 0,    0, 1, 0, 0,  0, L1);
      add(19,  0, 0,    0, 1, 0, 0,  0, L1);
      add(1,   0, 0,    1, 1, 0, 0,  1, L1);  // first timeout
      add(3,   0, 0,    1, 1, 0, 0,  1, L1);
      add(1,   0, 0,    0, 1, 0, 0,  1, L1);
      add(19,  0, 0,    0, 1, 0, 0,  1, L1);
      add(1,   0, 0,    1, 1, 0, 0,  2, L1);  // second timeout
      add(4,   0, 0,    0, 1, 0, 0,  2, L1);
      add(19,  0, 0,    0, 1, 0, 0,  2, L1);
      add(1,   0, 0,    1, 1, 0, 1,  2, L1);  // third timeout -> FAIL
      add(100, 0, 1,    1, 1, 0, 1,  2, L1);  // FAIL is sticky
      add(1,   1, 1,    1, 1, 0, 0,  0, 0);   // rst clears FAIL

      for (int i = 0; i < tbl.size(); i++) begin
         rst        = tbl[i].r;
         pll_locked = tbl[i].lk;
         repeat (tbl[i].n) tick();
         checks++;
         if ({pll_rst, sys_rst, ready, fail} !== {tbl[i].pr, tbl[i].sr, tbl[i].rd, tbl[i].fl} ||
             int'(retry_cnt) != tbl[i].rc || int'(lock_loss_cnt) != tbl[i].llc) begin
            errors++;
            $display("FAIL vec[%0d] actual pr/sr/rdy/fl/rc/llc=%b%b%b%b/%0d/%0d required=%b%b%b%b/%0d/%0d",
                     i, pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt,
                     tbl[i].pr, tbl[i].sr, tbl[i].rd, tbl[i].fl, tbl[i].rc, tbl[i].llc);
         end
      end

      // Glitch while stabilising: 5 high, 1 low, then high.
      rst = 1'b0;
      pll_locked = 1'b0;
      k = 0;
      while (pll_rst && k < 50) begin tick(); k++; end
      check("glitch_pll_rst_release", int'(pll_rst), 0);
      saw_pr = 1'b0;
      saw_rc = 1'b0;
      pll_locked = 1'b1;
      repeat (5) begin tick(); saw_pr |= pll_rst; saw_rc |= (retry_cnt != 0); end
      pll_locked = 1'b0;
      tick();
      saw_pr |= pll_rst;
      pll_locked = 1'b1;
      edges = 0;
      while (!ready && edges < 30) begin
         tick();
         edges++;
         saw_pr |= pll_rst;
         saw_rc |= (retry_cnt != 0);
      end
      check("glitch_ready_edge", edges, 11);
      check("glitch_no_pll_rst", int'(saw_pr), 0);
      check("glitch_retry_unchanged", int'(saw_rc), 0);

      // Reset while stabilising.
      pll_locked = 1'b0;
      k = 0;
      while (!pll_rst && k < 10) begin tick(); k++; end
      k = 0;
      while (pll_rst && k < 10) begin tick(); k++; end
      check("stab_reach_wait", int'(pll_rst), 0);
      pll_locked = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check("stab_rst_outputs", int'({pll_rst, sys_rst, ready, fail}), 4'b1100);
      check("stab_rst_retry", int'(retry_cnt), 0);
      check("stab_rst_llc", int'(lock_loss_cnt), 0);
      rst = 1'b0;

      // Repeated lock loss to exercise counter saturation.
      timed_out = 1'b0;
      for (int i = 0; i < 260 && !timed_out; i++) begin
         pll_locked = 1'b1;
         k = 0;
         while (!ready && k < 40) begin tick(); k++; end
         if (!ready) timed_out = 1'b1;
         pll_locked = 1'b0;
         k = 0;
         while (ready && k < 10) begin tick(); k++; end
         if (ready) timed_out = 1'b1;
         if (i == 9) check("loss_cnt_10", int'(lock_loss_cnt), LOSS_EN ? 10 : 0);
      end
      check("sat_no_timeout", int'(timed_out), 0);
      check("loss_cnt_saturated", int'(lock_loss_cnt), LOSS_EN ? 255 : 0);

      // Random lock waveform with occasional resets.
      k = 0;
      for (int i = 0; i < 3000; i++) begin
         if (k == 0) begin
            pll_locked = 1'($urandom_range(0, 1));
            k = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 25);
         end
         k--;
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences and supervises the 50 MHz-to-200 MHz system PLL, running in the refclk domain.
- Drives the PLL reset and consumes the PLL's asynchronous locked output.
- Qualifies lock over a stability window, then releases a system reset and asserts ready.
- Retries the PLL on lock timeout, restarts on loss of lock, and flags a sticky failure after repeated retries.

Parameters:
- PLL_RST_CYCLES, default 16: refclk cycles that pll_rst is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT, default 50000: refclk cycles to wait for lock per attempt (1 ms at 50 MHz).
- STABLE_CYCLES, default 1024: cycles the synchronised lock must stay high before release (>=1).
- MAX_RETRIES, default 3: PLL reset retries allowed before FAIL.
- RETRY_W: localparam, $clog2(MAX_RETRIES+1), minimum 1.

Ports:
- refclk  in  1  50 MHz reference clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- pll_rst  out  1  reset to the PLL rst input; active-high.
- sys_rst  out  1  active-high reset for downstream logic; each consumer resynchronises it into its own domain.
- ready  out  1  high while the PLL is qualified and running.
- fail  out  1  sticky; PLL never locked within the retry budget.
- retry_cnt  out  RETRY_W  retries consumed in the current lock episode.
- lock_loss_cnt  out  8  lock-loss events (see Optional Feature).

Behaviour:
- One clock and a synchronous active-high reset, as decided: clock port refclk, reset port rst.
- Reset values:
  - pll_rst=1, sys_rst=1, ready=0, fail=0.
  - retry_cnt=0, lock_loss_cnt=0, state=RESET_PLL, cycle counter=0.
  - Synchroniser flops=0.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s (2 edges of latency). Only locked_s is used by the state machine.
- All outputs are registers updated on the same edge as the state transition. No combinational paths exist from input to output.
- Cycle counter: one shared counter, cleared on every state entry.
- State RESET_PLL:
  - Outputs: pll_rst=1, sys_rst=1, ready=0.
  - When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK; otherwise increment the counter.
- State WAIT_LOCK:
  - Outputs: pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABILIZE.
  - Else if counter==LOCK_TIMEOUT-1:
    - If retry_cnt==MAX_RETRIES, go to FAIL.
    - Otherwise increment retry_cnt and go to RESET_PLL.
  - Else increment the counter.
- State STABILIZE:
  - Outputs: pll_rst=0, sys_rst=1.
  - If locked_s=0, return to WAIT_LOCK. This is a glitch: it does not count as a retry, and the counter restarts.
  - Else if counter==STABLE_CYCLES-1, go to RUN.
  - Else increment the counter.
  - Consequence: ready rises exactly 3+STABLE_CYCLES edges after the first edge that samples pll_locked=1, provided lock stays high.
- State RUN:
  - Outputs: sys_rst=0, ready=1, pll_rst=0, retry_cnt cleared to 0 on entry.
  - If locked_s=0, go to RESET_PLL on that edge: sys_rst=1, ready=0, and pll_rst=1 all take effect on the same edge.
- State FAIL:
  - Outputs: pll_rst=1 (PLL held off), sys_rst=1, ready=0, fail=1.
  - Only rst exits FAIL.
- Simultaneous events: a lock timeout and locked_s rising on the same edge go to STABILIZE (lock wins).
- rst asserted in any state returns all registers to reset values on the next edge, including mid-stabilise and mid-RUN.
- Counter width is $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The counter never wraps, because every state exits at its terminal count.

Optional Feature:
- Macro: PLL_LOCK_SUPERVISOR_LOSS_CNT_EN.
- Defined: lock_loss_cnt increments by 1 on each RUN-to-RESET_PLL transition and saturates at 255. Only rst clears it.
- Undefined: no counter logic is built, and lock_loss_cnt is tied to 8'd0.
- All other behaviour is identical with or without the macro.

Test Plan:
- Use parameters PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2 for all scenarios.
- Normal lock:
  - Stimulus: release rst; raise pll_locked 3 cycles after pll_rst falls.
  - Required: pll_rst high for exactly 4 cycles after rst release.
  - Required: ready=1 and sys_rst=0 exactly 11 edges after pll_locked is first sampled high; retry_cnt=0.
- Timeout and retry:
  - Stimulus: keep pll_locked=0.
  - Required: pll_rst re-pulses (4 cycles) after each 20-cycle wait; retry_cnt goes 1, then 2.
  - Required: after the third timeout, fail=1, pll_rst=1 and ready=0, held for 100 further cycles.
- Glitch during stabilise:
  - Stimulus: pll_locked high for 5 cycles, low for 1 cycle, then high.
  - Required: no pll_rst pulse; retry_cnt unchanged; ready rises 11 edges after the second rise.
- Lock loss in RUN:
  - Stimulus: reach RUN, then drop pll_locked.
  - Required: exactly 2 edges later, sys_rst=1, ready=0 and pll_rst=1.
  - Required: with the macro defined, lock_loss_cnt=1; without it, lock_loss_cnt=0.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during STABILIZE, and again during FAIL.
  - Required: on the next edge, all outputs equal their reset values and fail clears.
- Saturation (macro defined):
  - Stimulus: 260 lock-loss cycles.
  - Required: lock_loss_cnt stops at 255.
